// File: rtl/cv32e40p_rvfi_pkg.sv
// Shared types for the CV32E40P RVFI retirement queue: entry lifecycle states and the
// per-instruction record held from issue until in-order retire.
package cv32e40p_rvfi_pkg;

  typedef enum logic [1:0] {
    ENTRY_FREE = 2'd0,
    ENTRY_PEND = 2'd1,
    ENTRY_DONE = 2'd2
  } entry_state_e;

  typedef struct packed {
    entry_state_e state;
    logic [31:0]  insn;
    logic [31:0]  pc;
    logic         trap;
    logic [4:0]   rd_addr;
    logic [31:0]  rd_wdata;
    logic [31:0]  start_cycle;
  } entry_t;

  // x0 is hardwired to zero, so RVFI must never report a nonzero write to it.
  function automatic logic [31:0] rd_wdata_mask(input logic [4:0]  rd_addr,
                                                input logic [31:0] wdata);
    return (rd_addr == 5'd0) ? 32'd0 : wdata;
  endfunction

endpackage

// File: rtl/cv32e40p_rvfi_retire.sv
// In-order retirement queue feeding the RVFI trace port: entries are issued at the tail,
// completed either at issue or by a late writeback, and retired one per cycle from the head.
module cv32e40p_rvfi_retire
  import cv32e40p_rvfi_pkg::*;
#(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned TAG_W = $clog2(DEPTH)
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             issue_valid_i,
  output logic             issue_ready_o,
  input  logic [31:0]      issue_insn_i,
  input  logic [31:0]      issue_pc_i,
  input  logic             issue_trap_i,
  input  logic [4:0]       issue_rd_addr_i,
  input  logic [31:0]      issue_rd_wdata_i,
  input  logic             issue_late_i,
  output logic [TAG_W-1:0] issue_tag_o,
  input  logic             wb_valid_i,
  input  logic [TAG_W-1:0] wb_tag_i,
  input  logic [31:0]      wb_data_i,
  output logic             rvfi_valid_o,
  output logic [31:0]      rvfi_insn_o,
  output logic [31:0]      rvfi_pc_rdata_o,
  output logic             rvfi_trap_o,
  output logic [4:0]       rvfi_rd_addr_o,
  output logic [31:0]      rvfi_rd_wdata_o,
  output logic [31:0]      rvfi_start_cycle_o,
  output logic [31:0]      rvfi_stop_cycle_o,
  output logic [63:0]      rvfi_order_o,
  output logic             error_o
);

  localparam logic [TAG_W:0]   OccFull = (TAG_W+1)'(DEPTH);
  localparam logic [TAG_W-1:0] TagOne  = TAG_W'(1);

  entry_t           entries_q [DEPTH];
  entry_t           entries_d [DEPTH];
  logic [TAG_W-1:0] head_q, head_d, tail_q, tail_d;
  logic [TAG_W:0]   occ_q, occ_d;
  logic [31:0]      cycle_q;
  logic [63:0]      order_q;
  logic             error_q;

  entry_t           head_entry_s;
  logic             issue_accept_s, wb_hit_s, wb_err_s, retire_s;

  logic             rvfi_valid_q, rvfi_trap_q;
  logic [31:0]      rvfi_insn_q, rvfi_pc_q, rvfi_wdata_q, rvfi_start_q, rvfi_stop_q;
  logic [4:0]       rvfi_rd_q;
  logic [63:0]      rvfi_order_q;

  // Event decode: all decisions come from registered state, so a retire never frees room this cycle.
  always_comb begin
    head_entry_s   = entries_q[head_q];
    issue_accept_s = issue_valid_i && (occ_q < OccFull);
    retire_s       = (head_entry_s.state == ENTRY_DONE);
    if (wb_valid_i) begin
      wb_hit_s = (entries_q[wb_tag_i].state == ENTRY_PEND) &&
                 !(issue_accept_s && (wb_tag_i == tail_q));
      wb_err_s = !wb_hit_s;
    end else begin
      wb_hit_s = 1'b0;
      wb_err_s = 1'b0;
    end
  end

  // Queue next state; issue, writeback and retire always land on distinct entries.
  always_comb begin
    for (int unsigned i = 0; i < DEPTH; i++) begin
      entries_d[i] = entries_q[i];
      if (issue_accept_s && (tail_q == TAG_W'(i))) begin
        entries_d[i].state       = issue_late_i ? ENTRY_PEND : ENTRY_DONE;
        entries_d[i].insn        = issue_insn_i;
        entries_d[i].pc          = issue_pc_i;
        entries_d[i].trap        = issue_trap_i;
        entries_d[i].rd_addr     = issue_rd_addr_i;
        entries_d[i].rd_wdata    = issue_late_i ? 32'd0 : issue_rd_wdata_i;
        entries_d[i].start_cycle = cycle_q;
      end else if (wb_hit_s && (wb_tag_i == TAG_W'(i))) begin
        entries_d[i].state    = ENTRY_DONE;
        entries_d[i].rd_wdata = wb_data_i;
      end else if (retire_s && (head_q == TAG_W'(i))) begin
        entries_d[i].state = ENTRY_FREE;
      end else begin
        entries_d[i] = entries_q[i];
      end
    end
    head_d = retire_s ? (head_q + TagOne) : head_q;
    tail_d = issue_accept_s ? (tail_q + TagOne) : tail_q;
    occ_d  = occ_q + {{TAG_W{1'b0}}, issue_accept_s} - {{TAG_W{1'b0}}, retire_s};
  end

  // Queue, pointers, cycle counter, retire order and sticky error.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        entries_q[i] <= '0;
      end
      head_q  <= '0;
      tail_q  <= '0;
      occ_q   <= '0;
      cycle_q <= 32'd0;
      order_q <= 64'd0;
      error_q <= 1'b0;
    end else begin
      entries_q <= entries_d;
      head_q    <= head_d;
      tail_q    <= tail_d;
      occ_q     <= occ_d;
      cycle_q   <= cycle_q + 32'd1;
      order_q   <= retire_s ? (order_q + 64'd1) : order_q;
      error_q   <= error_q | wb_err_s;
    end
  end

  // RVFI trace register: loaded from the head on retire, otherwise holds the last record.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rvfi_valid_q <= 1'b0;
      rvfi_insn_q  <= 32'd0;
      rvfi_pc_q    <= 32'd0;
      rvfi_trap_q  <= 1'b0;
      rvfi_rd_q    <= 5'd0;
      rvfi_wdata_q <= 32'd0;
      rvfi_start_q <= 32'd0;
      rvfi_stop_q  <= 32'd0;
      rvfi_order_q <= 64'd0;
    end else begin
      rvfi_valid_q <= retire_s;
      if (retire_s) begin
        rvfi_insn_q  <= head_entry_s.insn;
        rvfi_pc_q    <= head_entry_s.pc;
        rvfi_trap_q  <= head_entry_s.trap;
        rvfi_rd_q    <= head_entry_s.rd_addr;
        rvfi_wdata_q <= rd_wdata_mask(head_entry_s.rd_addr, head_entry_s.rd_wdata);
        rvfi_start_q <= head_entry_s.start_cycle;
        rvfi_stop_q  <= cycle_q + 32'd1;
        rvfi_order_q <= order_q;
      end
    end
  end

  assign issue_ready_o      = (occ_q < OccFull);
  assign issue_tag_o        = tail_q;
  assign error_o            = error_q;
  assign rvfi_valid_o       = rvfi_valid_q;
  assign rvfi_insn_o        = rvfi_insn_q;
  assign rvfi_pc_rdata_o    = rvfi_pc_q;
  assign rvfi_trap_o        = rvfi_trap_q;
  assign rvfi_rd_addr_o     = rvfi_rd_q;
  assign rvfi_rd_wdata_o    = rvfi_wdata_q;
  assign rvfi_start_cycle_o = rvfi_start_q;
  assign rvfi_stop_cycle_o  = rvfi_stop_q;
  assign rvfi_order_o       = rvfi_order_q;

endmodule

// File: tb/tb_cv32e40p_rvfi_retire.sv
// Self-checking bench: directed scenarios plus randomized traffic, compared every cycle
// against a program-order queue model of the retirement rules.
module tb_cv32e40p_rvfi_retire;
  localparam int DEPTH = 4;
  localparam int TAG_W = 2;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic             rst_n;
  logic             iv, ready, trap, late, wv;
  logic [31:0]      insn, pc, wdata, wbd;
  logic [4:0]       rd;
  logic [TAG_W-1:0] tag, wtag;
  logic             r_valid, r_trap, err;
  logic [31:0]      r_insn, r_pc, r_wdata, r_start, r_stop;
  logic [4:0]       r_rd;
  logic [63:0]      r_order;

  cv32e40p_rvfi_retire #(.DEPTH(DEPTH), .TAG_W(TAG_W)) dut (
    .clk_i(clk), .rst_ni(rst_n),
    .issue_valid_i(iv), .issue_ready_o(ready), .issue_insn_i(insn), .issue_pc_i(pc),
    .issue_trap_i(trap), .issue_rd_addr_i(rd), .issue_rd_wdata_i(wdata), .issue_late_i(late),
    .issue_tag_o(tag),
    .wb_valid_i(wv), .wb_tag_i(wtag), .wb_data_i(wbd),
    .rvfi_valid_o(r_valid), .rvfi_insn_o(r_insn), .rvfi_pc_rdata_o(r_pc), .rvfi_trap_o(r_trap),
    .rvfi_rd_addr_o(r_rd), .rvfi_rd_wdata_o(r_wdata), .rvfi_start_cycle_o(r_start),
    .rvfi_stop_cycle_o(r_stop), .rvfi_order_o(r_order), .error_o(err)
  );

  typedef struct {
    logic [31:0] insn, pc, wdata, start;
    logic        trap;
    logic [4:0]  rd;
    bit          pend;
  } ent_t;

  ent_t        mq[$];
  int          m_head;
  logic [31:0] m_cnt;
  logic [63:0] m_order;
  bit          m_err;
  bit          e_valid, e_trap;
  logic [31:0] e_insn, e_pc, e_wdata, e_start, e_stop;
  logic [4:0]  e_rd;
  logic [63:0] e_order;
  int          checks = 0;
  int          errors = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, m_cnt);
    end
  endtask

  task automatic compare_all();
    chk("ready",  64'(ready), 64'(mq.size() < DEPTH));
    chk("tag",    64'(tag), 64'((m_head + mq.size()) % DEPTH));
    chk("error",  64'(err), 64'(m_err));
    chk("valid",  64'(r_valid), 64'(e_valid));
    chk("insn",   64'(r_insn), 64'(e_insn));
    chk("pc",     64'(r_pc), 64'(e_pc));
    chk("trap",   64'(r_trap), 64'(e_trap));
    chk("rd",     64'(r_rd), 64'(e_rd));
    chk("wdata",  64'(r_wdata), 64'(e_wdata));
    chk("start",  64'(r_start), 64'(e_start));
    chk("stop",   64'(r_stop), 64'(e_stop));
    chk("order",  r_order, e_order);
  endtask

  task automatic model_reset();
    mq.delete();
    m_head = 0; m_cnt = 32'd0; m_order = 64'd0; m_err = 1'b0;
    e_valid = 1'b0; e_trap = 1'b0; e_insn = 32'd0; e_pc = 32'd0; e_wdata = 32'd0;
    e_start = 32'd0; e_stop = 32'd0; e_rd = 5'd0; e_order = 64'd0;
  endtask

  // Advance the model by one clock using the inputs currently driven.
  task automatic model_step();
    int   sz0, idx;
    bit   ret;
    ent_t e;
    sz0 = mq.size();
    ret = (sz0 > 0) && !mq[0].pend;
    if (wv) begin
      idx = (int'(wtag) - m_head + DEPTH) % DEPTH;
      if (idx < sz0 && mq[idx].pend) begin
        mq[idx].pend  = 1'b0;
        mq[idx].wdata = wbd;
      end else begin
        m_err = 1'b1;
      end
    end
    e_valid = ret;
    if (ret) begin
      e_insn = mq[0].insn; e_pc = mq[0].pc; e_trap = mq[0].trap; e_rd = mq[0].rd;
      e_wdata = (mq[0].rd == 5'd0) ? 32'd0 : mq[0].wdata;
      e_start = mq[0].start; e_stop = m_cnt + 32'd1; e_order = m_order;
      m_order = m_order + 64'd1;
      void'(mq.pop_front());
      m_head = (m_head + 1) % DEPTH;
    end
    if (iv && sz0 < DEPTH) begin
      e.insn = insn; e.pc = pc; e.trap = trap; e.rd = rd;
      e.wdata = late ? 32'd0 : wdata; e.start = m_cnt; e.pend = late;
      mq.push_back(e);
    end
    m_cnt = m_cnt + 32'd1;
  endtask

  task automatic cycle();
    model_step();
    @(posedge clk);
    @(negedge clk);
    compare_all();
  endtask

  task automatic set_idle();
    iv = 1'b0; late = 1'b0; insn = 32'd0; pc = 32'd0; trap = 1'b0; rd = 5'd0; wdata = 32'd0;
    wv = 1'b0; wtag = '0; wbd = 32'd0;
  endtask

  task automatic set_issue(input logic l, input logic [31:0] i, input logic [31:0] p,
                           input logic [4:0] r, input logic [31:0] d);
    iv = 1'b1; late = l; insn = i; pc = p; trap = 1'b0; rd = r; wdata = d;
  endtask

  task automatic set_wb(input logic [TAG_W-1:0] t, input logic [31:0] d);
    wv = 1'b1; wtag = t; wbd = d;
  endtask

  task automatic idle_cycles(input int n);
    for (int k = 0; k < n; k++) begin
      set_idle();
      cycle();
    end
  endtask

  task automatic do_reset();
    set_idle();
    rst_n = 1'b0;
    #1;
    chk("rst_valid_async", 64'(r_valid), 64'd0);
    model_reset();
    @(posedge clk);
    @(negedge clk);
    compare_all();
    rst_n = 1'b1;
  endtask

  initial begin
    int   pend_idx[$];
    int   r;
    rst_n = 1'b0;
    set_idle();
    model_reset();
    @(negedge clk);

    // Single non-late issue at cycle 10 retires at cycle 12.
    do_reset();
    for (int k = 0; k < 20 && m_cnt != 32'd10; k++) idle_cycles(1);
    set_issue(1'b0, 32'h00500093, 32'h80, 5'd1, 32'd5);
    cycle();
    chk("s1_no_early_valid", 64'(r_valid), 64'd0);
    idle_cycles(1);
    chk("s1_valid",  64'(r_valid), 64'd1);
    chk("s1_order",  r_order, 64'd0);
    chk("s1_start",  64'(r_start), 64'd10);
    chk("s1_stop",   64'(r_stop), 64'd12);
    chk("s1_wdata",  64'(r_wdata), 64'd5);
    chk("s1_insn",   64'(r_insn), 64'h00500093);
    idle_cycles(1);
    chk("s1_pulse",  64'(r_valid), 64'd0);

    // Late load then ALU op; writeback three cycles after the load.
    do_reset();
    chk("s2_tag0", 64'(tag), 64'd0);
    set_issue(1'b1, 32'h00012083, 32'h200, 5'd1, 32'hFFFF);
    cycle();
    chk("s2_tag1", 64'(tag), 64'd1);
    set_issue(1'b0, 32'h00700113, 32'h204, 5'd2, 32'd7);
    cycle();
    idle_cycles(1);
    set_idle(); set_wb(2'd0, 32'hDEAD);
    cycle();
    chk("s2_wait", 64'(r_valid), 64'd0);
    idle_cycles(1);
    chk("s2_v0",     64'(r_valid), 64'd1);
    chk("s2_data0",  64'(r_wdata), 64'hDEAD);
    chk("s2_order0", r_order, 64'd0);
    idle_cycles(1);
    chk("s2_v1",     64'(r_valid), 64'd1);
    chk("s2_data1",  64'(r_wdata), 64'd7);
    chk("s2_order1", r_order, 64'd1);

    // Full queue: fifth issue waits until the cycle after the head retires.
    do_reset();
    for (int k = 0; k < 4; k++) begin
      set_issue(1'b1, 32'h1000 + 32'(k), 32'h100 + 32'(4 * k), 5'(k + 1), 32'd0);
      cycle();
    end
    chk("s3_full", 64'(ready), 64'd0);
    set_issue(1'b0, 32'h5555, 32'h110, 5'd5, 32'h55);
    set_wb(2'd0, 32'hA0);
    cycle();
    chk("s3_still_full", 64'(ready), 64'd0);
    wv = 1'b0;
    cycle();
    chk("s3_room",   64'(ready), 64'd1);
    chk("s3_retire", 64'(r_valid), 64'd1);
    cycle();
    chk("s3_refull", 64'(ready), 64'd0);
    for (int k = 1; k < 4; k++) begin
      set_idle(); set_wb(2'(k), 32'hB0 + 32'(k));
      cycle();
    end
    idle_cycles(6);

    // Writeback to a FREE tag sets a sticky error and leaves the queue alone.
    do_reset();
    set_wb(2'd2, 32'hBAD);
    cycle();
    chk("s4_err", 64'(err), 64'd1);
    set_idle(); set_issue(1'b0, 32'h13, 32'h300, 5'd3, 32'h55);
    cycle();
    idle_cycles(3);
    chk("s4_sticky", 64'(err), 64'd1);

    // rd = 0 reports zero write data.
    set_issue(1'b0, 32'h13, 32'h304, 5'd0, 32'h1234);
    cycle();
    idle_cycles(1);
    chk("s5_valid", 64'(r_valid), 64'd1);
    chk("s5_wdata", 64'(r_wdata), 64'd0);

    // Reset with three entries in flight discards them.
    do_reset();
    for (int k = 0; k < 3; k++) begin
      set_issue(1'b1, 32'h2000 + 32'(k), 32'h400 + 32'(4 * k), 5'd4, 32'd0);
      cycle();
    end
    do_reset();
    set_issue(1'b0, 32'h33, 32'h500, 5'd6, 32'h66);
    cycle();
    chk("s6_no_ghost", 64'(r_valid), 64'd0);
    idle_cycles(1);
    chk("s6_valid", 64'(r_valid), 64'd1);
    chk("s6_order", r_order, 64'd0);
    chk("s6_start", 64'(r_start), 64'd0);
    chk("s6_stop",  64'(r_stop), 64'd2);
    idle_cycles(2);

    // Randomized traffic, with one reset in the middle.
    do_reset();
    for (int n = 0; n < 3000; n++) begin
      if (n == 1500) do_reset();
      set_idle();
      if ($urandom_range(0, 99) < 60) begin
        set_issue(1'($urandom_range(0, 1)), $urandom, $urandom,
                  ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom_range(1, 31)), $urandom);
        trap = 1'($urandom_range(0, 1));
      end
      pend_idx.delete();
      for (int k = 0; k < mq.size(); k++) if (mq[k].pend) pend_idx.push_back(k);
      r = $urandom_range(0, 99);
      if (r < 2) begin
        set_wb(2'($urandom_range(0, DEPTH - 1)), $urandom);
      end else if (r < 50 && pend_idx.size() > 0) begin
        set_wb(2'((m_head + pend_idx[$urandom_range(0, pend_idx.size() - 1)]) % DEPTH), $urandom);
      end
      cycle();
    end
    idle_cycles(4);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
